// File: rtl/sr_scan_display_driver.sv
// Multiplexed 7-segment driver for a two-byte 74HC595 chain (segment byte, then digit-select byte).
// Each refresh slot serialises one 16-bit frame for the current digit on sclk/dio, then pulses rclk.
module sr_scan_display_driver #(
    parameter int clk_mhz        = 100,
    parameter int sclk_khz       = 1000,
    parameter int refresh_hz     = 1000,
    parameter int w_digit        = 4,
    parameter int seg_active_low = 0,
    parameter int sel_active_low = 0,
    parameter int lsb_first      = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*w_digit-1:0]   number,
    input  logic [w_digit-1:0]     dots,
    input  logic [w_digit-1:0]     digit_en,
    output logic                   sclk,
    output logic                   rclk,
    output logic                   dio,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int HALF   = clk_mhz * 1000 / (2 * sclk_khz);
    localparam int SLOT   = clk_mhz * 1000000 / (refresh_hz * w_digit);
    localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int IDX_W  = (w_digit > 1) ? $clog2(w_digit) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_LATCH
    } state_t;

    state_t state, state_nx;

    logic [SLOT_W-1:0] slot_cnt;
    logic [HALF_W-1:0] half_cnt;
    logic [3:0]        bit_cnt;
    logic [IDX_W-1:0]  idx;
    logic              pending;
    logic [15:0]       sh;
    logic              tick;
    logic              half_done;
    logic [3:0]        digit;
    logic [7:0]        seg;
    logic [7:0]        sel;
    logic [15:0]       frame_c;

    assign tick      = (slot_cnt == SLOT_W'(SLOT - 1));
    assign half_done = (half_cnt == HALF_W'(HALF - 1));

    function automatic logic [7:0] seg_map(input logic [3:0] h);
        case (h)
            4'h0: seg_map = 8'hFC;  4'h1: seg_map = 8'h60;
            4'h2: seg_map = 8'hDA;  4'h3: seg_map = 8'hF2;
            4'h4: seg_map = 8'h66;  4'h5: seg_map = 8'hB6;
            4'h6: seg_map = 8'hBE;  4'h7: seg_map = 8'hE0;
            4'h8: seg_map = 8'hFE;  4'h9: seg_map = 8'hF6;
            4'hA: seg_map = 8'hEE;  4'hB: seg_map = 8'h3E;
            4'hC: seg_map = 8'h9C;  4'hD: seg_map = 8'h7A;
            4'hE: seg_map = 8'h9E;  default: seg_map = 8'h8E;
        endcase
    endfunction

    // Blanking clears the dot too; polarity inversion comes last so a blanked digit is truly dark.
    always_comb begin
        digit = number[4*idx +: 4];
        seg   = seg_map(digit) | {7'b0, dots[idx]};
        if (!digit_en[idx]) seg = 8'h00;
        if (seg_active_low != 0) seg = ~seg;
        sel = 8'h01 << idx;
        if (sel_active_low != 0) sel = ~sel;
        frame_c = {seg, sel};
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (tick || pending) state_nx = S_LOAD;
            S_LOAD:     state_nx = S_SHIFT_LO;
            S_SHIFT_LO: if (half_done) state_nx = S_SHIFT_HI;
            S_SHIFT_HI: if (half_done) state_nx = (bit_cnt == 4'd15) ? S_LATCH : S_SHIFT_LO;
            S_LATCH:    if (half_done) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            slot_cnt <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            pending  <= 1'b0;
            sh       <= '0;
        end else begin
            state    <= state_nx;
            slot_cnt <= tick ? '0 : slot_cnt + 1'b1;
            if (state_nx != state)
                half_cnt <= '0;
            else if (state == S_SHIFT_LO || state == S_SHIFT_HI || state == S_LATCH)
                half_cnt <= half_cnt + 1'b1;
            if (state == S_LOAD)
                bit_cnt <= '0;
            else if (state == S_SHIFT_HI && half_done)
                bit_cnt <= bit_cnt + 1'b1;
            // A pending request meeting a fresh tick in IDLE keeps pending set, so neither is lost.
            if (state == S_IDLE) begin
                if (tick || pending) pending <= pending && tick;
            end else if (tick) begin
                pending <= 1'b1;
            end
            if (state == S_LOAD)
                sh <= (lsb_first != 0) ? (frame_c >> 1) : (frame_c << 1);
            else if (state == S_SHIFT_HI && half_done && bit_cnt != 4'd15)
                sh <= (lsb_first != 0) ? (sh >> 1) : (sh << 1);
            if (state == S_LATCH && half_done)
                idx <= (idx == IDX_W'(w_digit - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Pin outputs are registered from the next state so the 595 chain never sees decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk       <= 1'b0;
            rclk       <= 1'b0;
            dio        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sclk       <= (state_nx == S_SHIFT_HI);
            rclk       <= (state_nx == S_LATCH);
            busy       <= (state_nx != S_IDLE);
            frame_done <= (state == S_LATCH) && half_done;
            overrun    <= tick && (state != S_IDLE) && pending;
            if (state == S_LOAD)
                dio <= (lsb_first != 0) ? frame_c[0] : frame_c[15];
            else if (state == S_SHIFT_HI && half_done && bit_cnt != 4'd15)
                dio <= (lsb_first != 0) ? sh[0] : sh[15];
        end
    end

endmodule
